// File: rtl/regfile_wb_writer.sv
// Write-back front end for the register file write port.
// Accepts single or dual results over valid/ready and removes any half that
// targets r15. Queues the results in a small FIFO and drains one entry per
// cycle onto the regfile write port. Also publishes a per-register pending mask.
module regfile_wb_writer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_dual,
  input  logic [AW-1:0] req_wa,
  input  logic [AW-1:0] req_wa2,
  input  logic [DW-1:0] req_wd,
  input  logic [DW-1:0] req_wd2,
  input  logic          stall_wb,
  output logic [1:0]    we3,
  output logic [AW-1:0] wa3,
  output logic [AW-1:0] wa3_2,
  output logic [DW-1:0] wd3,
  output logic [DW-1:0] wd3_2,
  output logic [15:0]   pending,
  output logic          dropped
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [AW-1:0] PC_REG = AW'(15);

  typedef struct packed {
    logic          dual;
    logic [AW-1:0] wa;
    logic [AW-1:0] wa2;
    logic [DW-1:0] wd;
    logic [DW-1:0] wd2;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          ready_en;
  logic          push;
  logic          pop;
  logic          store;
  logic          drop;
  logic          keep1;
  logic          keep2;
  entry_t        new_entry;
  entry_t        head;

  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign count     = wr_ptr - rd_ptr;
  assign req_ready = ready_en & ~full;
  assign push      = req_valid & req_ready;
  assign pop       = ~empty & ~stall_wb;
  assign head      = mem[rd_ptr[PW-1:0]];

  assign keep1 = (req_wa != PC_REG);
  assign keep2 = req_dual && (req_wa2 != PC_REG);

  // Normalise an incoming request: strip r15 halves and merge same-address duals
  always_comb begin
    new_entry = '0;
    store     = 1'b0;
    drop      = push && ((req_wa == PC_REG) || (req_dual && (req_wa2 == PC_REG)));
    if (keep1 && keep2) begin
      if (req_wa == req_wa2) begin
        // Both halves hit one register: the second half's data wins.
        new_entry.wa = req_wa;
        new_entry.wd = req_wd2;
      end else begin
        new_entry.dual = 1'b1;
        new_entry.wa   = req_wa;
        new_entry.wd   = req_wd;
        new_entry.wa2  = req_wa2;
        new_entry.wd2  = req_wd2;
      end
    end else if (keep1) begin
      new_entry.wa = req_wa;
      new_entry.wd = req_wd;
    end else if (keep2) begin
      new_entry.wa = req_wa2;
      new_entry.wd = req_wd2;
    end
    if (push && (keep1 || keep2)) begin
      store = 1'b1;
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr[PW-1:0]] <= new_entry;
    end
  end

  // Pointers, handshake enable, drop pulse and the presented write
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ready_en <= 1'b0;
      dropped  <= 1'b0;
      we3      <= '0;
      wa3      <= '0;
      wa3_2    <= '0;
      wd3      <= '0;
      wd3_2    <= '0;
    end else begin
      ready_en <= 1'b1;
      dropped  <= drop;
      if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        we3    <= head.dual ? 2'b11 : 2'b01;
        wa3    <= head.wa;
        wa3_2  <= head.wa2;
        wd3    <= head.wd;
        wd3_2  <= head.wd2;
      end else begin
        we3 <= '0;
      end
    end
  end

  // Pending mask: every queued entry plus the write currently on the port
  always_comb begin
    logic [15:0]   pend;
    logic [PW-1:0] idx;
    pend = '0;
    idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr[PW-1:0] + PW'(k);
      if ((PW+1)'(k) < count) begin
        pend = pend | (16'(1) << mem[idx].wa);
        if (mem[idx].dual) begin
          pend = pend | (16'(1) << mem[idx].wa2);
        end
      end
    end
    if (we3 != 2'b00) begin
      pend = pend | (16'(1) << wa3);
    end
    if (we3 == 2'b11) begin
      pend = pend | (16'(1) << wa3_2);
    end
    pend[15] = 1'b0;
    pending  = pend;
  end

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Scoreboard bench for regfile_wb_writer: the driver pushes normalised
// expected writes, the monitor checks the write port, pending, ready and dropped.
module tb_regfile_wb_writer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_dual;
  logic [3:0]  req_wa;
  logic [3:0]  req_wa2;
  logic [31:0] req_wd;
  logic [31:0] req_wd2;
  logic        stall_wb;
  logic [1:0]  we3;
  logic [3:0]  wa3;
  logic [3:0]  wa3_2;
  logic [31:0] wd3;
  logic [31:0] wd3_2;
  logic [15:0] pending;
  logic        dropped;

  regfile_wb_writer #(.DEPTH(4), .AW(4), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_dual(req_dual),
    .req_wa(req_wa), .req_wa2(req_wa2), .req_wd(req_wd), .req_wd2(req_wd2),
    .stall_wb(stall_wb),
    .we3(we3), .wa3(wa3), .wa3_2(wa3_2), .wd3(wd3), .wd3_2(wd3_2),
    .pending(pending), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
  } wr_t;

  wr_t q[$];
  int  tests = 0;
  int  fails = 0;
  bit  last_push = 0;
  bit  exp_drop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; records the expected writes if a transfer happens
  task automatic send(input bit v, input bit du, input logic [3:0] a, input logic [3:0] a2,
                      input logic [31:0] d, input logic [31:0] d2, input bit st, input bit rs,
                      output bit fired);
    wr_t e;
    @(negedge clk);
    #1;
    req_valid = v; req_dual = du; req_wa = a; req_wa2 = a2;
    req_wd = d; req_wd2 = d2; stall_wb = st; reset = rs;
    #1;
    fired = v && req_ready && !rs;
    if (fired) begin
      exp_drop = (a == 4'd15) || (du && a2 == 4'd15);
      e.n = 0; e.a0 = '0; e.a1 = '0; e.d0 = '0; e.d1 = '0;
      if (a != 4'd15) begin
        e.a0 = a; e.d0 = d; e.n = 1;
      end
      if (du && a2 != 4'd15) begin
        if (e.n == 1 && e.a0 == a2) begin
          e.d0 = d2;
        end else if (e.n == 1) begin
          e.a1 = a2; e.d1 = d2; e.n = 2;
        end else begin
          e.a0 = a2; e.d0 = d2; e.n = 1;
        end
      end
      if (e.n > 0) begin
        q.push_back(e);
        last_push = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    bit f;
    repeat (n) send(0, 0, 0, 0, 0, 0, 0, 0, f);
  endtask

  // Monitor: runs at each negedge, before the driver changes inputs
  initial begin
    wr_t         e;
    bit          rs_s;
    bit          st_s;
    int          avail;
    logic [15:0] pexp;
    forever begin
      @(negedge clk);
      rs_s = reset;
      st_s = stall_wb;
      if (rs_s) begin
        q.delete();
        check("reset_we3", we3, 0);
        check("reset_pending", pending, 0);
        check("reset_ready", req_ready, 0);
        check("reset_dropped", dropped, 0);
      end else begin
        check("dropped", dropped, exp_drop);
        avail = q.size() - (last_push ? 1 : 0);
        pexp = '0;
        if (!st_s && avail > 0) begin
          e = q.pop_front();
          check("we3", we3, (e.n == 2) ? 2'b11 : 2'b01);
          check("wa3", wa3, e.a0);
          check("wd3", wd3, e.d0);
          pexp[e.a0] = 1'b1;
          if (e.n == 2) begin
            check("wa3_2", wa3_2, e.a1);
            check("wd3_2", wd3_2, e.d1);
            pexp[e.a1] = 1'b1;
          end
        end else begin
          check("we3_idle", we3, 0);
        end
        foreach (q[i]) begin
          pexp[q[i].a0] = 1'b1;
          if (q[i].n == 2) pexp[q[i].a1] = 1'b1;
        end
        check("pending", pending, pexp);
        check("ready", req_ready, q.size() < 4);
      end
      last_push = 0;
      exp_drop  = 0;
    end
  end

  initial begin
    bit f;
    int k;
    int guard;
    logic [3:0] a;
    logic [3:0] a2;
    reset = 1; req_valid = 0; req_dual = 0; req_wa = 0; req_wa2 = 0;
    req_wd = 0; req_wd2 = 0; stall_wb = 0;
    repeat (2) send(0, 0, 0, 0, 0, 0, 0, 1, f);
    idle(2);

    // Directed writes, normalisation and r15 filtering
    send(1, 0, 3, 0, 32'hDEADBEEF, 0, 0, 0, f); idle(3);
    send(1, 1, 4, 5, 1, 2, 0, 0, f); idle(2);
    send(1, 1, 6, 6, 7, 9, 0, 0, f); idle(2);
    send(1, 1, 15, 2, 11, 22, 0, 0, f); idle(2);
    send(1, 0, 15, 0, 33, 0, 0, 0, f); idle(2);
    send(1, 1, 7, 15, 44, 55, 0, 0, f); idle(2);

    // Backpressure: fill while stalled, 5th held, then release
    k = 1;
    repeat (7) begin
      send(1, 0, 4'(k), 0, 32'(k * 16), 0, 1, 0, f);
      if (f) k++;
    end
    guard = 0;
    while (k <= 5 && guard < 12) begin
      send(1, 0, 4'(k), 0, 32'(k * 16), 0, 0, 0, f);
      if (f) k++;
      guard++;
    end
    check("backpressure_accept", k, 6);
    idle(6);

    // Steady stream while full and draining
    repeat (4) send(1, 0, 9, 0, 99, 0, 1, 0, f);
    for (int i = 0; i < 20; i++) send(1, i[0], 4'(i % 15), 4'((i + 3) % 15), i, i + 100, 0, 0, f);
    idle(6);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) send(1, 0, 4'(i + 8), 0, i, 0, 1, 0, f);
    send(0, 0, 0, 0, 0, 0, 0, 1, f);
    idle(6);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      a  = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      a2 = ($urandom_range(0, 4) == 0) ? 4'd15 :
           ($urandom_range(0, 4) == 0) ? a : 4'($urandom_range(0, 15));
      send($urandom_range(0, 9) < 7, 1'($urandom), a, a2, $urandom, $urandom,
           $urandom_range(0, 9) < 3, $urandom_range(0, 199) == 0, f);
    end

    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      idle(1);
      guard++;
    end
    idle(2);
    check("drain_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
